// File: rtl/tick_monitor.sv
// rtl/tick_monitor.sv - synchronises a slow square wave, emits edge ticks, measures half-periods and tracks rate lock
module tick_monitor #(
  parameter int NOM_HALF = 50_001,
  parameter int TOL      = 500,
  parameter int LOCK_CNT = 4,
  parameter int CW       = 18
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          i_sq,
  output logic          o_tick_rise,
  output logic          o_tick_fall,
  output logic [CW-1:0] o_half_period,
  output logic          o_period_valid,
  output logic          o_locked,
  output logic          o_lost
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] TIMEOUT_C = CW'(2 * NOM_HALF - 1);
  localparam logic [CW-1:0] LO_C      = CW'(NOM_HALF - TOL);
  localparam logic [CW-1:0] HI_C      = CW'(NOM_HALF + TOL);
  localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, hist_q;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [CW-1:0] half_q, half_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          lost_q, lost_d;
  logic [GW-1:0] good_q, good_d;

  logic          edge_det;
  logic          timeout;
  logic          in_range;
  logic [CW-1:0] meas;

  assign edge_det = sync2_q ^ hist_q;
  // Saturated counter only occurs in SEARCH, where meas is never published.
  assign meas     = (counter_q == CNT_MAX) ? CNT_MAX : counter_q + 1'b1;
  assign in_range = (meas >= LO_C) && (meas <= HI_C);
  assign timeout  = (counter_q == TIMEOUT_C);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    lost_d    = lost_q;
    half_d    = half_q;
    valid_d   = 1'b0;
    rise_d    = edge_det & sync2_q;
    fall_d    = edge_det & ~sync2_q;
    counter_d = (counter_q == CNT_MAX) ? CNT_MAX : counter_q + 1'b1;
    if (edge_det) begin
      counter_d = '0;
    end

    // An edge always takes priority over a coincident timeout.
    case (state_q)
      SEARCH: begin
        if (edge_det) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (edge_det) begin
          half_d  = meas;
          valid_d = 1'b1;
          if (in_range) begin
            good_d = good_q + 1'b1;
            if (good_q == LAST_GOOD) begin
              state_d = LOCKED;
              lost_d  = 1'b0;
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          half_d  = meas;
          valid_d = 1'b1;
          if (!in_range) begin
            state_d = TRACK;
            good_d  = '0;
            lost_d  = 1'b1;
          end
        end else if (timeout) begin
          state_d = SEARCH;
          lost_d  = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      counter_q <= '0;
      half_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
      good_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= i_sq;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      counter_q <= counter_d;
      half_q    <= half_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
      good_q    <= good_d;
    end
  end

  assign o_tick_rise    = rise_q;
  assign o_tick_fall    = fall_q;
  assign o_half_period  = half_q;
  assign o_period_valid = valid_q;
  assign o_locked       = locked_q;
  assign o_lost         = lost_q;

endmodule

// File: tb/tb_tick_monitor.sv
// tb/tb_tick_monitor.sv - directed and randomised square-wave stimulus against a tick-level reference model
module tb_tick_monitor;

  localparam int NOM  = 10;
  localparam int TOL  = 1;
  localparam int LCK  = 4;
  localparam int CW   = 8;
  localparam int TOUT = 2 * NOM;

  logic          clk_100MHz = 1'b0;
  logic          reset_n    = 1'b0;
  logic          i_sq       = 1'b0;
  logic          o_tick_rise, o_tick_fall, o_period_valid, o_locked, o_lost;
  logic [CW-1:0] o_half_period;

  tick_monitor #(.NOM_HALF(NOM), .TOL(TOL), .LOCK_CNT(LCK), .CW(CW)) dut (
    .clk_100MHz    (clk_100MHz),
    .reset_n       (reset_n),
    .i_sq          (i_sq),
    .o_tick_rise   (o_tick_rise),
    .o_tick_fall   (o_tick_fall),
    .o_half_period (o_half_period),
    .o_period_valid(o_period_valid),
    .o_locked      (o_locked),
    .o_lost        (o_lost)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int   t;
    logic d;
  } tick_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  tick_t pend[$];

  // Model state: 0 searching, 1 tracking, 2 locked
  logic          m_lvl = 1'b0;
  int            m_st = 0, m_good = 0, m_last = 0;
  logic          m_rise = 0, m_fall = 0, m_valid = 0, m_locked = 0, m_lost = 0;
  logic [CW-1:0] m_half = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // A level change sampled at posedge n appears as a tick just after posedge n+2.
  task automatic model_step();
    int    meas;
    tick_t tk;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_valid = 1'b0;
    if (!reset_n) begin
      pend.delete();
      m_lvl = 1'b0; m_st = 0; m_good = 0;
      m_half = '0; m_locked = 1'b0; m_lost = 1'b0;
      return;
    end
    if (i_sq !== m_lvl) begin
      tk.t = cyc + 2;
      tk.d = i_sq;
      pend.push_back(tk);
      m_lvl = i_sq;
    end
    if (pend.size() > 0 && pend[0].t == cyc) begin
      tk = pend.pop_front();
      m_rise = tk.d;
      m_fall = !tk.d;
      if (m_st == 0) begin
        m_st = 1; m_good = 0;
      end else begin
        meas    = cyc - m_last;
        m_half  = CW'(meas);
        m_valid = 1'b1;
        if (meas >= NOM - TOL && meas <= NOM + TOL) begin
          if (m_st == 1) begin
            m_good++;
            if (m_good == LCK) begin
              m_st = 2; m_lost = 1'b0;
            end
          end
        end else begin
          if (m_st == 2) m_lost = 1'b1;
          m_st = 1; m_good = 0;
        end
      end
      m_last = cyc;
    end else if (m_st != 0 && cyc - m_last == TOUT) begin
      if (m_st == 2) m_lost = 1'b1;
      m_st = 0;
    end
    m_locked = (m_st == 2);
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    cyc++;
    model_step();
    #1;
    chk("tick_rise", 32'(o_tick_rise), 32'(m_rise));
    chk("tick_fall", 32'(o_tick_fall), 32'(m_fall));
    chk("period_valid", 32'(o_period_valid), 32'(m_valid));
    chk("half_period", 32'(o_half_period), 32'(m_half));
    chk("locked", 32'(o_locked), 32'(m_locked));
    chk("lost", 32'(o_lost), 32'(m_lost));
  endtask

  task automatic half(input int h);
    i_sq = ~i_sq;
    repeat (h) step();
  endtask

  task automatic hold(input int h);
    repeat (h) step();
  endtask

  initial begin
    int r;
    reset_n = 1'b0;
    i_sq    = 1'b0;
    hold(3);
    chk("reset_half", 32'(o_half_period), 32'd0);
    chk("reset_locked", 32'(o_locked), 32'd0);
    reset_n = 1'b1;
    hold(5);

    repeat (8) half(10);
    chk("lock_10", 32'(o_locked), 32'd1);
    chk("half_10", 32'(o_half_period), 32'd10);

    repeat (6) half(12);
    chk("nolock_12", 32'(o_locked), 32'd0);
    chk("half_12", 32'(o_half_period), 32'd12);

    repeat (6) half(8);
    chk("nolock_8", 32'(o_locked), 32'd0);
    chk("half_8", 32'(o_half_period), 32'd8);

    repeat (6) half(9);
    chk("lock_9", 32'(o_locked), 32'd1);
    repeat (6) half(11);
    chk("lock_11", 32'(o_locked), 32'd1);
    chk("half_11", 32'(o_half_period), 32'd11);

    hold(25);
    chk("timeout_locked", 32'(o_locked), 32'd0);
    chk("timeout_lost", 32'(o_lost), 32'd1);

    repeat (6) half(10);
    chk("relock", 32'(o_locked), 32'd1);
    half(13);
    half(10);
    chk("glitch_locked", 32'(o_locked), 32'd0);
    chk("glitch_lost", 32'(o_lost), 32'd1);
    repeat (4) half(10);
    chk("recover_locked", 32'(o_locked), 32'd1);
    chk("recover_lost", 32'(o_lost), 32'd0);

    if (i_sq == 1'b0) half(10);
    reset_n = 1'b0;
    step();
    chk("mid_reset_locked", 32'(o_locked), 32'd0);
    reset_n = 1'b1;
    step();
    step();
    step();
    chk("post_reset_rise", 32'(o_tick_rise), 32'd1);
    chk("post_reset_valid", 32'(o_period_valid), 32'd0);
    hold(4);

    repeat (60) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        hold($urandom_range(15, 25));
      end else if (r == 1) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else if (r < 12) begin
        half($urandom_range(9, 11));
      end else begin
        half($urandom_range(5, 14));
      end
    end
    hold(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
